clk_div_prog: RTL
=================

# clk_div_prog

Programmable integer clock divider for the PLL block: the parametrised successor to the fixed 8-bit divider. It derives `pclk` from `Ref_Clk` for any ratio from 2 to 2^RATIO_W−1. Odd ratios give a near-50% duty cycle. Ratio changes apply glitch-free at period boundaries. A same-domain `pclk_en` strobe and a lock indicator are provided for downstream PCS logic.

## Interface
Parameters:
- `RATIO_W`, 8, width of the division-ratio field.
- `DEFAULT_RATIO`, 20, active ratio after reset; must be ≥2 and <2^RATIO_W.
- `LOCK_PERIODS`, 4, number of complete output periods at a stable ratio before `lock` asserts.

Ports:
- `Ref_Clk`  in  1  reference clock; the only clock.
- `rst`  in  1  synchronous reset, active-low.
- `div_ratio`  in  RATIO_W  requested division ratio.
- `ratio_load`  in  1  capture `div_ratio` on this edge.
- `pclk`  out  1  divided clock, registered.
- `pclk_en`  out  1  one-`Ref_Clk` pulse coincident with each `pclk` rising edge.
- `ratio_ack`  out  1  one-cycle pulse when a pending ratio becomes active.
- `ratio_err`  out  1  one-cycle pulse when a loaded ratio of 0 or 1 is clamped.
- `lock`  out  1  output stable (see Configuration).

## Operation
- Registers:
  - `act`: active ratio, N.
  - `cnt`: phase counter, 0..N−1.
  - `pend`, `pend_v`: shadow ratio and its valid flag.
  - `pclk`, `pclk_en`, `ratio_ack`, `ratio_err`.
  - `per_cnt`: lock period counter.
- Period rules:
  - High phase H = (N+1)>>1; low phase = N−H.
  - Ratio 20 gives 10 high / 10 low; ratio 7 gives 4 high / 3 low.
- Each edge out of reset:
  - Wrap condition W = (cnt == act−1).
  - cnt_next = W ? 0 : cnt+1.
  - `pclk` <= (cnt_next < H), where H uses the ratio valid for the period cnt_next belongs to.
  - `pclk_en` <= W.
- Load:
  - `ratio_load`=1 writes clamp(`div_ratio`) into `pend` and sets `pend_v`.
  - clamp maps 0 and 1 to 2 and pulses `ratio_err` on the next edge.
  - A later load before application overwrites `pend`; last load wins.
- Apply:
  - On an edge with W=1 and `pend_v`=1: `act`<=`pend`, `pend_v`<=0, `ratio_ack`<=1 for one cycle.
  - The new period starts high with H computed from the new ratio, so no runt pulse is possible.
- Simultaneous events:
  - A load on the same edge as W does not apply to that wrap; it becomes pending and applies at the next wrap.
  - A pending value already held at that edge is applied; the new load value is then pending.
- Reset (`rst`=0 at a `Ref_Clk` edge), reached from any state including mid-period:
  - `act`=DEFAULT_RATIO, `cnt`=DEFAULT_RATIO−1, `pend_v`=0.
  - `pclk`=0, `pclk_en`=0, `ratio_ack`=0, `ratio_err`=0, `lock`=0, `per_cnt`=0.
  - Any pending ratio is discarded.

## Timing
- `pclk` and `pclk_en` rise on the first edge sampling `rst`=1: one cycle after release.
- Output period is exactly N `Ref_Clk` cycles; `pclk` falls on the edge where cnt_next = H.
- Latency from `ratio_load` to `ratio_ack`:
  - Minimum 1 cycle (load edge immediately precedes the wrap edge).
  - Maximum N_old cycles (load on a wrap edge).
- `ratio_err` follows its load by exactly one cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
Macro `CLK_DIV_LOCK_EN`:
- Defined:
  - `per_cnt` increments on each W edge, saturating at LOCK_PERIODS.
  - `lock`=1 while `per_cnt`==LOCK_PERIODS.
  - On the edge a ratio is applied, `per_cnt` clears and `lock` deasserts.
  - With LOCK_PERIODS=4 and ratio 20, `lock` asserts on the 4th wrap after release, i.e. 80 cycles after the first `pclk` rise.
- Undefined:
  - No `per_cnt` register.
  - `lock` is `rst`-registered: 0 in reset, 1 from the first edge after release.

## Test plan
- Reset release, DEFAULT_RATIO=20, no loads -> `pclk` rises 1 cycle after release; 10 cycles high / 10 low; `pclk_en` pulses every 20 cycles aligned with `pclk` rise.
- Load 7 mid-period at ratio 20 -> `ratio_ack` on the next wrap; previous period completes at 20; subsequent periods 4 high / 3 low; no pulse shorter than 3 cycles.
- Load 0, then separately load 1 -> `ratio_err` pulse one cycle after each; ratio 2 applied (1 high / 1 low); `ratio_ack` at the following wrap.
- Load 9 then load 5 within the same period -> single `ratio_ack`; ratio 5 active (3 high / 2 low); ratio 9 never appears. Load coincident with wrap -> applies at the next wrap.
- Assert `rst`=0 for one edge at cnt=6 with a ratio pending -> all outputs 0 on that edge; ratio 20 restored; pending ratio lost; `pclk` rises on the first edge after release.
- With `CLK_DIV_LOCK_EN`, ratio 20 -> `lock` rises at the 4th wrap and drops on the edge a new ratio applies. Without the macro -> `lock`=1 from the first edge after release.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: pclk = Ref_Clk / N, N in 2..2^RATIO_W-1,
// with glitch-free ratio changes at period boundaries. Optional macro CLK_DIV_LOCK_EN.
module clk_div_prog #(
  parameter int unsigned RATIO_W       = 8,
  parameter int unsigned DEFAULT_RATIO = 20,
  parameter int unsigned LOCK_PERIODS  = 4
) (
  input  logic               Ref_Clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] div_ratio,
  input  logic               ratio_load,
  output logic               pclk,
  output logic               pclk_en,
  output logic               ratio_ack,
  output logic               ratio_err,
  output logic               lock
);

  localparam logic [RATIO_W-1:0] DEF_R = RATIO_W'(DEFAULT_RATIO);
  localparam logic [RATIO_W-1:0] MIN_R = RATIO_W'(2);
  localparam logic [RATIO_W-1:0] ONE   = RATIO_W'(1);

  logic [RATIO_W-1:0] act_q, act_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic               pclk_q, pclk_d;
  logic               pclk_en_q, pclk_en_d;
  logic               ack_q, ack_d;
  logic               err_det_q, err_det_d;
  logic               err_q, err_d;
  logic               lock_q, lock_d;

  logic               wrap;
  logic               apply;
  logic               clamp;
  logic [RATIO_W:0]   high_len;

  always_comb begin
    wrap      = (cnt_q == act_q - ONE);
    apply     = wrap & pend_v_q;
    cnt_d     = wrap ? '0 : cnt_q + ONE;
    act_d     = apply ? pend_q : act_q;
    // high phase length follows the ratio of the period cnt_d belongs to
    high_len  = ({1'b0, act_d} + (RATIO_W+1)'(1)) >> 1;
    pclk_d    = ({1'b0, cnt_d} < high_len);
    pclk_en_d = wrap;
    ack_d     = apply;

    clamp     = (div_ratio < MIN_R);
    pend_d    = pend_q;
    pend_v_d  = pend_v_q & ~apply;
    if (ratio_load) begin
      pend_d   = clamp ? MIN_R : div_ratio;
      pend_v_d = 1'b1;
    end
    err_det_d = ratio_load & clamp;
    err_d     = err_det_q;
  end

`ifdef CLK_DIV_LOCK_EN
  localparam int unsigned PW = (LOCK_PERIODS > 0) ? $clog2(LOCK_PERIODS + 1) : 1;
  localparam logic [PW-1:0] LP_MAX = PW'(LOCK_PERIODS);

  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic          run_q;

  // the wrap on the release edge only starts the first period, so it is not counted
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (apply) begin
      per_cnt_d = '0;
    end else if (wrap && run_q && (per_cnt_q != LP_MAX)) begin
      per_cnt_d = per_cnt_q + PW'(1);
    end
    lock_d = (per_cnt_d == LP_MAX);
  end

  always_ff @(posedge Ref_Clk) begin
    if (!rst) begin
      per_cnt_q <= '0;
      run_q     <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      run_q     <= 1'b1;
    end
  end
`else
  always_comb begin
    lock_d = 1'b1;
  end
`endif

  always_ff @(posedge Ref_Clk) begin
    if (!rst) begin
      act_q     <= DEF_R;
      cnt_q     <= DEF_R - ONE;
      pend_q    <= MIN_R;
      pend_v_q  <= 1'b0;
      pclk_q    <= 1'b0;
      pclk_en_q <= 1'b0;
      ack_q     <= 1'b0;
      err_det_q <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      pclk_q    <= pclk_d;
      pclk_en_q <= pclk_en_d;
      ack_q     <= ack_d;
      err_det_q <= err_det_d;
      err_q     <= err_d;
      lock_q    <= lock_d;
    end
  end

  assign pclk      = pclk_q;
  assign pclk_en   = pclk_en_q;
  assign ratio_ack = ack_q;
  assign ratio_err = err_q;
  assign lock      = lock_q;

endmodule
